iob_sram_responder: RTL and testbench



---
 rtl/iob_sram_responder.sv | 188 ++++++++++++++++++
 tb/tb_iob_sram_responder.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_sram_responder.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// iob_sram_responder
//
// Responder on the IOb native bus, backed by an internal word-addressed RAM.
// A request is accepted in IDLE and answered WAIT_STATES+1 cycles later with a
// one-cycle ready pulse. The RAM write, or the rdata load for a read, happens on
// the edge that enters RESP. Serves as the boot/simulation memory behind the
// CPU wrapper.
//
// Optional feature: define IOB_SRAM_RESP_RANGE_CHK_EN to flag requests whose
// address has any bit set at or above MEM_ADDR_W+OFF_W. Such writes are dropped,
// such reads return 0, and err goes high until reset. Without the macro the
// upper address bits alias and err is tied low.
//
// Parameters
//   ADDR_W       byte address width
//   DATA_W       data width, multiple of 8
//   MEM_ADDR_W   RAM depth is 2**MEM_ADDR_W words
//   WAIT_STATES  extra cycles between acceptance and ready, 0..15
//
// Ports
//   clk      clock, all state on rising edge
//   rst      asynchronous reset, active low
//   valid    request valid, held by the initiator until ready
//   address  byte address (offset bits ignored, accesses word aligned)
//   wdata    write data
//   wstrb    byte write enables; nonzero = write, zero = read
//   ready    one-cycle response pulse
//   rdata    read data, valid while ready=1; 0 for write responses
//   err      sticky out-of-range flag
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | waiting for valid; request captured on the accepting edge
// ST_WAIT  | counting down wait states; leaves when the counter is at 1
// ST_RESP  | ready high for this one cycle, then back to ST_IDLE
// -----------------------------------------------------------------------------
module iob_sram_responder #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int MEM_ADDR_W  = 10,
   parameter int WAIT_STATES = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                valid,
   input  logic [ADDR_W-1:0]   address,
   input  logic [DATA_W-1:0]   wdata,
   input  logic [DATA_W/8-1:0] wstrb,
   output logic                ready,
   output logic [DATA_W-1:0]   rdata,
   output logic                err
);

   localparam int         STRB_W = DATA_W / 8;
   localparam int         OFF_W  = $clog2(STRB_W);
   localparam int         IDX_LO = OFF_W;
   localparam int         IDX_HI = MEM_ADDR_W + OFF_W - 1;
   localparam int         DEPTH  = 2 ** MEM_ADDR_W;
   localparam logic [3:0] WS     = 4'(WAIT_STATES);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t                state;
   logic [3:0]            cnt;
   logic [MEM_ADDR_W-1:0] lat_idx;
   logic [DATA_W-1:0]     lat_wdata;
   logic [STRB_W-1:0]     lat_wstrb;
   logic                  lat_oor;

   logic [DATA_W-1:0]     mem [DEPTH];

   logic [MEM_ADDR_W-1:0] req_idx;
   logic [DATA_W-1:0]     req_wdata;
   logic [STRB_W-1:0]     req_wstrb;
   logic                  req_oor;
   logic                  addr_oor;
   logic                  enter_resp;
   logic                  commit;
   logic                  unused_addr;

   // Offset bits (and, without range checking, the upper bits) play no part.
   assign unused_addr = ^address;

`ifdef IOB_SRAM_RESP_RANGE_CHK_EN
   assign addr_oor = (address >> (IDX_HI + 1)) != '0;
`else
   assign addr_oor = 1'b0;
`endif

   // With zero wait states RESP is entered on the accepting edge itself, so the
   // request must come straight from the bus in IDLE and from the latches later.
   always_comb begin
      req_idx   = lat_idx;
      req_wdata = lat_wdata;
      req_wstrb = lat_wstrb;
      req_oor   = lat_oor;
      if (state == ST_IDLE) begin
         req_idx   = address[IDX_HI:IDX_LO];
         req_wdata = wdata;
         req_wstrb = wstrb;
         req_oor   = addr_oor;
      end
   end

   assign enter_resp = ((state == ST_IDLE) && valid && (WS == 4'd0)) ||
                       ((state == ST_WAIT) && (cnt <= 4'd1));

   // rst gates the RAM write: while reset is held the FSM sits in IDLE and a
   // live valid must not reach the array.
   assign commit = rst && enter_resp && (|req_wstrb) && !req_oor;

   always_ff @(posedge clk) begin
      if (commit) begin
         for (int i = 0; i < STRB_W; i++) begin
            if (req_wstrb[i]) begin
               mem[req_idx][i*8 +: 8] <= req_wdata[i*8 +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ST_IDLE;
         cnt       <= 4'd0;
         ready     <= 1'b0;
         rdata     <= '0;
         lat_idx   <= '0;
         lat_wdata <= '0;
         lat_wstrb <= '0;
         lat_oor   <= 1'b0;
`ifdef IOB_SRAM_RESP_RANGE_CHK_EN
         err       <= 1'b0;
`endif
      end else begin
         ready <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (valid) begin
                  lat_idx   <= req_idx;
                  lat_wdata <= req_wdata;
                  lat_wstrb <= req_wstrb;
                  lat_oor   <= req_oor;
                  cnt       <= WS;
                  state     <= (WS == 4'd0) ? ST_RESP : ST_WAIT;
               end
            end
            ST_WAIT: begin
               cnt <= cnt - 4'd1;
               if (cnt <= 4'd1) begin
                  state <= ST_RESP;
               end
            end
            ST_RESP: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase

         if (enter_resp) begin
            ready <= 1'b1;
            if ((|req_wstrb) || req_oor) begin
               rdata <= '0;
            end else begin
               rdata <= mem[req_idx];
            end
`ifdef IOB_SRAM_RESP_RANGE_CHK_EN
            if (req_oor) begin
               err <= 1'b1;
            end
`endif
         end
      end
   end

`ifndef IOB_SRAM_RESP_RANGE_CHK_EN
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_iob_sram_responder.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_iob_sram_responder
//
// Three responders with WAIT_STATES 0, 2 and 3 share the request bus; each has
// its own valid and reset. Expected read data, latency and err come from a
// byte-level memory model that tracks which bytes have been written.
// -----------------------------------------------------------------------------
module tb_iob_sram_responder;

   logic        clk = 1'b0;
   logic [2:0]  rst_n;
   logic [2:0]  vld;
   logic [31:0] address;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic [2:0]  rdy;
   logic [2:0]  er;
   logic [31:0] rdata [3];

   int checks = 0;
   int errors = 0;

   logic [31:0] mem_m [3][1024];
   logic [3:0]  kn_m  [3][1024];
   bit          err_m [3];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      iob_sram_responder #(
         .ADDR_W(32),
         .DATA_W(32),
         .MEM_ADDR_W(10),
         .WAIT_STATES(g == 0 ? 0 : (g == 1 ? 2 : 3))
      ) u_dut (
         .clk(clk),
         .rst(rst_n[g]),
         .valid(vld[g]),
         .address(address),
         .wdata(wdata),
         .wstrb(wstrb),
         .ready(rdy[g]),
         .rdata(rdata[g]),
         .err(er[g])
      );
   end

   function automatic int ws_of(input int d);
      return (d == 0) ? 0 : ((d == 1) ? 2 : 3);
   endfunction

   // Reference: word index = byte address / 4 modulo 1024; out of range when
   // the address is 0x1000 or above and range checking is built in.
   function automatic void model_xfer(input int d, input logic [31:0] a,
                                      input logic [31:0] wd, input logic [3:0] ws,
                                      output logic [31:0] exp, output logic [31:0] msk);
      int idx;
      bit oor;
      idx = int'((a / 4) % 1024);
      oor = 1'b0;
`ifdef IOB_SRAM_RESP_RANGE_CHK_EN
      oor = (a >= 32'h1000);
`endif
      exp = 32'h0;
      msk = 32'hFFFF_FFFF;
      if (oor) begin
         err_m[d] = 1'b1;
      end else if (ws != 4'h0) begin
         for (int b = 0; b < 4; b++) begin
            if (ws[b]) begin
               mem_m[d][idx][8*b +: 8] = wd[8*b +: 8];
               kn_m[d][idx][b] = 1'b1;
            end
         end
      end else begin
         exp = mem_m[d][idx];
         msk = 32'h0;
         for (int b = 0; b < 4; b++) begin
            if (kn_m[d][idx][b]) msk[8*b +: 8] = 8'hFF;
         end
      end
   endfunction

   // mode 0: normal; 1: change address(+4)/wdata after acceptance;
   // 2: drop valid right after acceptance.
   task automatic xfer(input int d, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] ws, input int mode,
                       output int lat, output logic [31:0] rd, output logic e);
      @(negedge clk);
      address = a;
      wdata   = wd;
      wstrb   = ws;
      vld[d]  = 1'b1;
      @(posedge clk);
      #1;
      if (mode == 1) begin
         address = a + 32'h4;
         wdata   = 32'h2222_2222;
      end
      if (mode == 2) vld[d] = 1'b0;
      lat = 1;
      while (rdy[d] !== 1'b1 && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
      if (rdy[d] !== 1'b1) lat = -1;
      rd = rdata[d];
      e  = er[d];
      vld[d] = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 3'b000;
      vld   = 3'b000;
      address = 32'h10;
      wdata = 32'h0;
      wstrb = 4'h0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         vld = ~vld;
         for (int d = 0; d < 3; d++) begin
            checks++;
            if (rdy[d] !== 1'b0 || rdata[d] !== 32'h0 || er[d] !== 1'b0) begin
               errors++;
               $display("FAIL reset_hold dut%0d: ready=%b rdata=%h err=%b, want 0/0/0",
                        d, rdy[d], rdata[d], er[d]);
            end
         end
      end
      @(negedge clk);
      vld = 3'b000;
      rst_n = 3'b111;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         checks++;
         if (rdy !== 3'b000) begin
            errors++;
            $display("FAIL idle_ready: ready=%b want 000", rdy);
         end
      end
   endtask

   task automatic test_read_after_write();
      int lat; logic [31:0] rd, exp, msk; logic e;
      model_xfer(1, 32'h10, 32'hDEAD_BEEF, 4'hF, exp, msk);
      xfer(1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, lat, rd, e);
      checks++;
      if (lat !== 3 || rd !== 32'h0) begin
         errors++;
         $display("FAIL raw_write: latency=%0d rdata=%h, want 3/00000000", lat, rd);
      end
      model_xfer(1, 32'h10, 32'h0, 4'h0, exp, msk);
      xfer(1, 32'h10, 32'h0, 4'h0, 0, lat, rd, e);
      checks++;
      if (lat !== 3 || rd !== 32'hDEAD_BEEF) begin
         errors++;
         $display("FAIL raw_read: latency=%0d rdata=%h, want 3/deadbeef", lat, rd);
      end
   endtask

   task automatic test_byte_strobe();
      int lat; logic [31:0] rd, exp, msk; logic e;
      model_xfer(1, 32'h10, 32'h0000_AA00, 4'b0010, exp, msk);
      xfer(1, 32'h10, 32'h0000_AA00, 4'b0010, 0, lat, rd, e);
      model_xfer(1, 32'h10, 32'h0, 4'h0, exp, msk);
      xfer(1, 32'h10, 32'h0, 4'h0, 0, lat, rd, e);
      checks++;
      if (rd !== 32'hDEAD_AAEF) begin
         errors++;
         $display("FAIL byte_strobe: rdata=%h want deadaaef", rd);
      end
   endtask

   task automatic test_inputs_ignored();
      int lat; logic [31:0] rd, exp, msk, r24; logic e;
      r24 = $urandom;
      model_xfer(1, 32'h24, r24, 4'hF, exp, msk);
      xfer(1, 32'h24, r24, 4'hF, 0, lat, rd, e);
      model_xfer(1, 32'h20, 32'h1111_1111, 4'hF, exp, msk);
      xfer(1, 32'h20, 32'h1111_1111, 4'hF, 1, lat, rd, e);
      xfer(1, 32'h20, 32'h0, 4'h0, 0, lat, rd, e);
      checks++;
      if (rd !== 32'h1111_1111) begin
         errors++;
         $display("FAIL ignore_addr20: rdata=%h want 11111111", rd);
      end
      xfer(1, 32'h24, 32'h0, 4'h0, 0, lat, rd, e);
      checks++;
      if (rd !== r24) begin
         errors++;
         $display("FAIL ignore_addr24: rdata=%h want %h", rd, r24);
      end
      // valid dropped right after acceptance: the write still completes
      model_xfer(1, 32'h28, 32'h5A5A_0F0F, 4'hF, exp, msk);
      xfer(1, 32'h28, 32'h5A5A_0F0F, 4'hF, 2, lat, rd, e);
      checks++;
      if (lat !== 3) begin
         errors++;
         $display("FAIL valid_drop_ready: latency=%0d want 3", lat);
      end
      xfer(1, 32'h28, 32'h0, 4'h0, 0, lat, rd, e);
      checks++;
      if (rd !== 32'h5A5A_0F0F) begin
         errors++;
         $display("FAIL valid_drop_data: rdata=%h want 5a5a0f0f", rd);
      end
   endtask

   task automatic test_back_to_back();
      int lat, pulses; int cyc[3]; logic [31:0] rd, msk, w; logic e;
      logic [31:0] exp[3];
      for (int i = 0; i < 3; i++) begin
         w = $urandom;
         model_xfer(0, 32'h40 + 32'(4*i), w, 4'hF, exp[i], msk);
         xfer(0, 32'h40 + 32'(4*i), w, 4'hF, 0, lat, rd, e);
         checks++;
         if (lat !== 1) begin
            errors++;
            $display("FAIL ws0_latency: latency=%0d want 1", lat);
         end
      end
      for (int i = 0; i < 3; i++) model_xfer(0, 32'h40 + 32'(4*i), 32'h0, 4'h0, exp[i], msk);
      @(negedge clk);
      address = 32'h40;
      wstrb = 4'h0;
      vld[0] = 1'b1;
      pulses = 0;
      for (int c = 1; c <= 12 && pulses < 3; c++) begin
         @(posedge clk);
         #1;
         if (rdy[0] === 1'b1) begin
            cyc[pulses] = c;
            checks++;
            if (rdata[0] !== exp[pulses]) begin
               errors++;
               $display("FAIL b2b_data%0d: rdata=%h want %h", pulses, rdata[0], exp[pulses]);
            end
            pulses++;
            address = 32'h40 + 32'(4*pulses);
            if (pulses == 3) vld[0] = 1'b0;
         end
      end
      vld[0] = 1'b0;
      checks++;
      if (pulses !== 3) begin
         errors++;
         $display("FAIL b2b_count: pulses=%0d want 3", pulses);
      end else begin
         checks++;
         if (cyc[0] !== 1 || cyc[1] !== 3 || cyc[2] !== 5) begin
            errors++;
            $display("FAIL b2b_spacing: cycles=%0d,%0d,%0d want 1,3,5", cyc[0], cyc[1], cyc[2]);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset_mid();
      int lat, n; logic [31:0] rd, exp, msk, a_val, b_val; logic e;
      a_val = $urandom;
      b_val = ~a_val;
      model_xfer(2, 32'h80, a_val, 4'hF, exp, msk);
      xfer(2, 32'h80, a_val, 4'hF, 0, lat, rd, e);
      checks++;
      if (lat !== 4) begin
         errors++;
         $display("FAIL ws3_latency: latency=%0d want 4", lat);
      end
      // reset while in WAIT: write must not land
      @(negedge clk);
      address = 32'h80; wdata = b_val; wstrb = 4'hF; vld[2] = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n[2] = 1'b0;
      vld[2] = 1'b0;
      #1;
      checks++;
      if (rdy[2] !== 1'b0) begin
         errors++;
         $display("FAIL rst_wait_ready: ready=%b want 0", rdy[2]);
      end
      err_m[2] = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n[2] = 1'b1;
      model_xfer(2, 32'h80, 32'h0, 4'h0, exp, msk);
      xfer(2, 32'h80, 32'h0, 4'h0, 0, lat, rd, e);
      checks++;
      if (lat !== 4 || rd !== a_val) begin
         errors++;
         $display("FAIL rst_wait_word: latency=%0d rdata=%h want 4/%h", lat, rd, a_val);
      end
      // reset during RESP: write already committed, ready/rdata drop at once
      model_xfer(2, 32'h84, b_val, 4'hF, exp, msk);
      @(negedge clk);
      address = 32'h84; wdata = b_val; wstrb = 4'hF; vld[2] = 1'b1;
      n = 0;
      while (rdy[2] !== 1'b1 && n < 40) begin
         @(posedge clk); #1; n++;
      end
      vld[2] = 1'b0;
      rst_n[2] = 1'b0;
      #1;
      checks++;
      if (n !== 4 || rdy[2] !== 1'b0 || rdata[2] !== 32'h0) begin
         errors++;
         $display("FAIL rst_resp: latency=%0d ready=%b rdata=%h want 4/0/0", n, rdy[2], rdata[2]);
      end
      err_m[2] = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n[2] = 1'b1;
      xfer(2, 32'h84, 32'h0, 4'h0, 0, lat, rd, e);
      checks++;
      if (rd !== b_val) begin
         errors++;
         $display("FAIL rst_resp_commit: rdata=%h want %h", rd, b_val);
      end
   endtask

   task automatic test_range();
      int lat; logic [31:0] rd, exp, msk, w0; logic e;
      w0 = $urandom;
      model_xfer(1, 32'h0, w0, 4'hF, exp, msk);
      xfer(1, 32'h0, w0, 4'hF, 0, lat, rd, e);
      model_xfer(1, 32'h1000, 32'hCAFE_F00D, 4'hF, exp, msk);
      xfer(1, 32'h1000, 32'hCAFE_F00D, 4'hF, 0, lat, rd, e);
      checks++;
      if (lat !== 3 || e !== err_m[1]) begin
         errors++;
         $display("FAIL range_write: latency=%0d err=%b want 3/%b", lat, e, err_m[1]);
      end
      model_xfer(1, 32'h0, 32'h0, 4'h0, exp, msk);
      xfer(1, 32'h0, 32'h0, 4'h0, 0, lat, rd, e);
`ifdef IOB_SRAM_RESP_RANGE_CHK_EN
      checks++;
      if (rd !== w0 || e !== 1'b1) begin
         errors++;
         $display("FAIL range_word0: rdata=%h err=%b want %h/1", rd, e, w0);
      end
`else
      checks++;
      if (rd !== 32'hCAFE_F00D || e !== 1'b0) begin
         errors++;
         $display("FAIL alias_word0: rdata=%h err=%b want cafef00d/0", rd, e);
      end
`endif
      model_xfer(1, 32'h1000, 32'h0, 4'h0, exp, msk);
      xfer(1, 32'h1000, 32'h0, 4'h0, 0, lat, rd, e);
      checks++;
      if (rd !== exp || e !== err_m[1]) begin
         errors++;
         $display("FAIL range_read: rdata=%h err=%b want %h/%b", rd, e, exp, err_m[1]);
      end
   endtask

   task automatic test_random();
      int lat; logic [31:0] rd, exp, msk, a, wd; logic [3:0] ws; logic e;
      for (int d = 0; d < 3; d++) begin
         for (int t = 0; t < 30; t++) begin
            a  = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
            if ($urandom_range(0, 4) == 0) a = a | ($urandom << 12);
            wd = $urandom;
            ws = ($urandom_range(0, 9) < 4) ? 4'h0 : 4'($urandom_range(1, 15));
            model_xfer(d, a, wd, ws, exp, msk);
            xfer(d, a, wd, ws, 0, lat, rd, e);
            checks++;
            if (lat !== ws_of(d) + 1 || (rd & msk) !== (exp & msk) || e !== err_m[d]) begin
               errors++;
               $display("FAIL random dut%0d a=%h ws=%h: lat=%0d rdata=%h err=%b want %0d/%h(mask %h)/%b",
                        d, a, ws, lat, rd, e, ws_of(d) + 1, exp, msk, err_m[d]);
            end
         end
      end
   endtask

   initial begin
      for (int d = 0; d < 3; d++) begin
         err_m[d] = 1'b0;
         for (int i = 0; i < 1024; i++) begin
            kn_m[d][i]  = 4'h0;
            mem_m[d][i] = 32'h0;
         end
      end
      test_reset();
      test_read_after_write();
      test_byte_strobe();
      test_inputs_ignored();
      test_back_to_back();
      test_reset_mid();
      test_range();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
